rr_mux_arbiter_8: RTL and testbench



---
 rtl/rr_mux_arbiter_8.sv | 105 ++++++++++
 tb/tb_rr_mux_arbiter_8.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_8.sv
// rr_mux_arbiter_8: round-robin arbiter and sequencer for a shared 8:1 mux.
// Eight W-bit lanes compete for one downstream valid/ready channel. Each
// grant is capped at MAX_BURST beats, and there is one IDLE cycle between
// consecutive grants.
module rr_mux_arbiter_8 #(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     Req,
  input  logic [8*W-1:0] In,
  input  logic           Ready,
  output logic           Valid,
  output logic [W-1:0]   Y,
  output logic [2:0]     Sel,
  output logic [7:0]     Gnt
);

  localparam int unsigned     CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   LAST = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_next;
  logic [2:0]    ptr, ptr_next;
  logic [2:0]    sel_next;
  logic [7:0]    gnt_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    pick, idx;
  logic          found;

  // Round-robin scan: first requester at or after ptr, wrapping 7 -> 0
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && Req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Output channel: owner's request is the valid; data is zeroed when idle
  always_comb begin
    Valid = (state == GRANT) && Req[Sel];
    Y     = Valid ? In[int'(Sel)*W +: W] : '0;
  end

  // Next-state logic for FSM, select, grant, pointer and beat counter
  always_comb begin
    state_next = state;
    sel_next   = Sel;
    gnt_next   = Gnt;
    ptr_next   = ptr;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        gnt_next = '0;
        if (found) begin
          sel_next   = pick;
          gnt_next   = 8'b1 << pick;
          cnt_next   = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        // An owner that drops Req releases without a transfer even if Ready
        // is high; otherwise the grant ends on the MAX_BURST-th transfer.
        if (!Valid || (Ready && cnt == LAST)) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = Sel + 3'd1;
        end else if (Ready) begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      Sel   <= '0;
      Gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      Sel   <= sel_next;
      Gnt   <= gnt_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Directed self-checking bench for rr_mux_arbiter_8 (MAX_BURST=4 and =1).
module tb_rr_mux_arbiter_8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  Req;
  logic [63:0] In;
  logic        Ready;
  logic        Valid, Valid1;
  logic [7:0]  Y, Y1;
  logic [2:0]  Sel, Sel1;
  logic [7:0]  Gnt, Gnt1;
  logic [7:0]  lane [8];

  int n_checks = 0;
  int n_fail   = 0;

  rr_mux_arbiter_8 #(.W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .In(In), .Ready(Ready),
    .Valid(Valid), .Y(Y), .Sel(Sel), .Gnt(Gnt)
  );

  rr_mux_arbiter_8 #(.W(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Req(Req), .In(In), .Ready(Ready),
    .Valid(Valid1), .Y(Y1), .Sel(Sel1), .Gnt(Gnt1)
  );

  always #5 clk = ~clk;

  always_comb begin
    In = '0;
    for (int i = 0; i < 8; i++) In[i*8 +: 8] = lane[i];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reset both DUTs and leave time at posedge+1 with IDLE, Ptr=0
  task automatic do_reset;
    rst_n = 1'b0;
    Req   = '0;
    Ready = 1'b0;
    for (int i = 0; i < 8; i++) lane[i] = 8'hA0 + 8'(i);
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset;
    Req = 8'hFF; Ready = 1'b1; rst_n = 1'b1;
    step(); step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({Gnt, Sel, Valid, Y} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset: got gnt=%h sel=%0d valid=%b y=%h, expected all zero", Gnt, Sel, Valid, Y);
    end
    do_reset();
    n_checks++;
    if ({Gnt, Sel, Valid, Y} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got gnt=%h sel=%0d valid=%b y=%h, expected all zero", Gnt, Sel, Valid, Y);
    end
  endtask

  task automatic test_single;
    do_reset();
    Req = 8'h08; Ready = 1'b1; lane[3] = 8'h30;
    for (int g = 0; g < 2; g++) begin
      for (int b = 0; b < 4; b++) begin
        step();
        n_checks++;
        if ({Gnt, Sel, Valid, Y} !== {8'h08, 3'd3, 1'b1, lane[3]}) begin
          n_fail++;
          $display("FAIL single g=%0d b=%0d: got gnt=%h sel=%0d valid=%b y=%h, expected gnt=08 sel=3 valid=1 y=%h",
                   g, b, Gnt, Sel, Valid, Y, lane[3]);
        end
        lane[3] = lane[3] + 8'd1;
      end
      step();
      n_checks++;
      if ({Gnt, Sel, Valid, Y} !== {8'h00, 3'd3, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL single_idle g=%0d: got gnt=%h sel=%0d valid=%b y=%h, expected gnt=00 sel=3 valid=0 y=00",
                 g, Gnt, Sel, Valid, Y);
      end
    end
  endtask

  task automatic test_contention;
    logic [2:0] id;
    do_reset();
    Req = 8'hFF; Ready = 1'b1;
    for (int g = 0; g < 9; g++) begin
      id = 3'(g % 8);
      for (int b = 0; b < 4; b++) begin
        step();
        n_checks++;
        if ({Gnt, Sel, Valid, Y} !== {8'b1 << id, id, 1'b1, lane[id]}) begin
          n_fail++;
          $display("FAIL contention g=%0d b=%0d: got gnt=%h sel=%0d valid=%b y=%h, expected lane %0d",
                   g, b, Gnt, Sel, Valid, Y, id);
        end
      end
      step();
      n_checks++;
      if ({Gnt, Sel, Valid, Y} !== {8'h00, id, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL contention_idle g=%0d: got gnt=%h sel=%0d valid=%b y=%h, expected idle sel=%0d",
                 g, Gnt, Sel, Valid, Y, id);
      end
    end
  endtask

  task automatic test_sparse;
    logic [2:0] order [4];
    order[0] = 3'd2; order[1] = 3'd7; order[2] = 3'd2; order[3] = 3'd7;
    do_reset();
    Req = 8'b1000_0100; Ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++) begin
        step();
        n_checks++;
        if ({Gnt, Sel, Valid, Y} !== {8'b1 << order[g], order[g], 1'b1, lane[order[g]]}) begin
          n_fail++;
          $display("FAIL sparse g=%0d b=%0d: got gnt=%h sel=%0d valid=%b y=%h, expected lane %0d",
                   g, b, Gnt, Sel, Valid, Y, order[g]);
        end
      end
      step();
      n_checks++;
      if ({Gnt, Valid} !== {8'h00, 1'b0}) begin
        n_fail++;
        $display("FAIL sparse_idle g=%0d: got gnt=%h valid=%b, expected gnt=00 valid=0", g, Gnt, Valid);
      end
    end
  endtask

  task automatic test_backpressure;
    logic rdy [6];
    rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b0;
    rdy[3] = 1'b1; rdy[4] = 1'b1; rdy[5] = 1'b1;
    do_reset();
    Req = 8'h20; lane[5] = 8'h50;
    step();
    for (int c = 0; c < 6; c++) begin
      Ready = rdy[c];
      #1;
      n_checks++;
      if ({Gnt, Sel, Valid, Y} !== {8'h20, 3'd5, 1'b1, lane[5]}) begin
        n_fail++;
        $display("FAIL backpressure c=%0d: got gnt=%h sel=%0d valid=%b y=%h, expected gnt=20 sel=5 valid=1 y=%h",
                 c, Gnt, Sel, Valid, Y, lane[5]);
      end
      step();
      if (rdy[c]) lane[5] = lane[5] + 8'd1;
    end
    n_checks++;
    if ({Gnt, Sel, Valid, Y} !== {8'h00, 3'd5, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL backpressure_release: got gnt=%h sel=%0d valid=%b y=%h, expected gnt=00 sel=5 valid=0 y=00",
               Gnt, Sel, Valid, Y);
    end
    Req = '0;
  endtask

  task automatic test_early_drop;
    do_reset();
    Req = 8'h42; Ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      step();
      n_checks++;
      if ({Gnt, Sel, Valid, Y} !== {8'h02, 3'd1, 1'b1, lane[1]}) begin
        n_fail++;
        $display("FAIL drop_beat b=%0d: got gnt=%h sel=%0d valid=%b y=%h, expected gnt=02 sel=1 valid=1",
                 b, Gnt, Sel, Valid, Y);
      end
    end
    step();
    Req = 8'h40;
    #1;
    n_checks++;
    if ({Gnt, Sel, Valid, Y} !== {8'h02, 3'd1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL drop_now: got gnt=%h sel=%0d valid=%b y=%h, expected gnt=02 sel=1 valid=0 y=00",
               Gnt, Sel, Valid, Y);
    end
    step();
    n_checks++;
    if ({Gnt, Sel, Valid, Y} !== {8'h00, 3'd1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL drop_idle: got gnt=%h sel=%0d valid=%b y=%h, expected gnt=00 sel=1 valid=0",
               Gnt, Sel, Valid, Y);
    end
    step();
    n_checks++;
    if ({Gnt, Sel, Valid, Y} !== {8'h40, 3'd6, 1'b1, lane[6]}) begin
      n_fail++;
      $display("FAIL drop_next: got gnt=%h sel=%0d valid=%b y=%h, expected gnt=40 sel=6 valid=1 y=%h",
               Gnt, Sel, Valid, Y, lane[6]);
    end
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    Req = 8'h10; Ready = 1'b1;
    step();
    step();
    n_checks++;
    if ({Gnt, Sel, Valid, Y} !== {8'h10, 3'd4, 1'b1, lane[4]}) begin
      n_fail++;
      $display("FAIL midrst_beat2: got gnt=%h sel=%0d valid=%b y=%h, expected gnt=10 sel=4 valid=1",
               Gnt, Sel, Valid, Y);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({Gnt, Sel, Valid, Y} !== 20'h0) begin
      n_fail++;
      $display("FAIL midrst_async: got gnt=%h sel=%0d valid=%b y=%h, expected all zero", Gnt, Sel, Valid, Y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) begin
      step();
      n_checks++;
      if ({Gnt, Sel, Valid, Y} !== {8'h10, 3'd4, 1'b1, lane[4]}) begin
        n_fail++;
        $display("FAIL midrst_regrant b=%0d: got gnt=%h sel=%0d valid=%b y=%h, expected gnt=10 sel=4 valid=1",
                 b, Gnt, Sel, Valid, Y);
      end
    end
    step();
    n_checks++;
    if ({Gnt, Valid} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_release: got gnt=%h valid=%b, expected gnt=00 valid=0", Gnt, Valid);
    end
  endtask

  task automatic test_burst1;
    logic [2:0] id;
    do_reset();
    Req = 8'hFF; Ready = 1'b1;
    for (int g = 0; g < 9; g++) begin
      id = 3'(g % 8);
      step();
      n_checks++;
      if ({Gnt1, Sel1, Valid1, Y1} !== {8'b1 << id, id, 1'b1, lane[id]}) begin
        n_fail++;
        $display("FAIL burst1 g=%0d: got gnt=%h sel=%0d valid=%b y=%h, expected lane %0d",
                 g, Gnt1, Sel1, Valid1, Y1, id);
      end
      step();
      n_checks++;
      if ({Gnt1, Valid1} !== {8'h00, 1'b0}) begin
        n_fail++;
        $display("FAIL burst1_idle g=%0d: got gnt=%h valid=%b, expected gnt=00 valid=0", g, Gnt1, Valid1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    Req   = '0;
    Ready = 1'b0;
    for (int i = 0; i < 8; i++) lane[i] = 8'hA0 + 8'(i);
    do_reset();
    test_reset();
    test_single();
    test_contention();
    test_sparse();
    test_backpressure();
    test_early_drop();
    test_reset_mid_burst();
    test_burst1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
